// File: rtl/display_arbiter.sv
// Fixed-priority owner of the 8-digit seven-segment path: grants one requester,
// holds it for a minimum time, and optionally routes its value through the BCD converter.
module display_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned HOLD_CYCLES  = 25000000,
    parameter int unsigned CONV_TIMEOUT = 255
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_value,
    input  logic [NUM_REQ-1:0]      req_decimal,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    conv_start,
    output logic [31:0]             conv_binary,
    input  logic [31:0]             conv_bcd,
    input  logic                    conv_done,
    output logic [31:0]             disp_value,
    output logic                    disp_valid,
    output logic                    overflow,
    output logic                    conv_error
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned TMO_W  = $clog2(CONV_TIMEOUT + 2);
    localparam logic [31:0] DEC_MAX = 32'd99999999;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_SHOW    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   own_idx_q, own_idx_d;
    logic [31:0]        lat_value_q, lat_value_d;
    logic               lat_dec_q, lat_dec_d;
    logic               conv_start_q, conv_start_d;
    logic [31:0]        conv_binary_q, conv_binary_d;
    logic [31:0]        disp_value_q, disp_value_d;
    logic               disp_valid_q, disp_valid_d;
    logic               overflow_q, overflow_d;
    logic               conv_error_q, conv_error_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic               any_req;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [31:0]        pick_value;
    logic               pick_dec;
    logic [31:0]        own_value;
    logic               own_dec;
    logic               own_req;
    logic               higher_req;
    logic               hold_done;

    // Lowest set request index wins; also mux out the owner's live inputs.
    always_comb begin
        any_req    = |req;
        pick_idx   = '0;
        pick_oh    = '0;
        pick_value = '0;
        pick_dec   = 1'b0;
        own_value  = '0;
        own_dec    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
        pick_oh[pick_idx] = any_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_value = req_value[32*i +: 32];
                pick_dec   = req_decimal[i];
            end
            if (IDX_W'(i) == own_idx_q) begin
                own_value = req_value[32*i +: 32];
                own_dec   = req_decimal[i];
            end
        end
        own_req    = |(req & grant_q);
        higher_req = |(req & (grant_q - NUM_REQ'(1)));
        hold_done  = (hold_cnt_q == HOLD_W'(HOLD_CYCLES));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        own_idx_d     = own_idx_q;
        lat_value_d   = lat_value_q;
        lat_dec_d     = lat_dec_q;
        conv_start_d  = 1'b0;
        conv_binary_d = conv_binary_q;
        disp_value_d  = disp_value_q;
        disp_valid_d  = disp_valid_q;
        overflow_d    = overflow_q;
        conv_error_d  = conv_error_q;
        hold_cnt_d    = hold_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                grant_d      = '0;
                disp_valid_d = 1'b0;
                if (any_req) begin
                    grant_d     = pick_oh;
                    own_idx_d   = pick_idx;
                    lat_value_d = pick_value;
                    lat_dec_d   = pick_dec;
                    hold_cnt_d  = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                overflow_d   = 1'b0;
                conv_error_d = 1'b0;
                if (lat_dec_q && (lat_value_q <= DEC_MAX)) begin
                    conv_binary_d = lat_value_q;
                    conv_start_d  = 1'b1;
                    tmo_cnt_d     = '0;
                    state_d       = ST_CONVERT;
                end else begin
                    overflow_d   = lat_dec_q;
                    disp_value_d = lat_value_q;
                    disp_valid_d = 1'b1;
                    state_d      = ST_SHOW;
                end
            end
            ST_CONVERT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (conv_done) begin
                    disp_value_d = conv_bcd;
                    disp_valid_d = 1'b1;
                    state_d      = ST_SHOW;
                end else if (tmo_cnt_d == TMO_W'(CONV_TIMEOUT)) begin
                    conv_error_d = 1'b1;
                    disp_value_d = lat_value_q;
                    disp_valid_d = 1'b1;
                    state_d      = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (!hold_done) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if (hold_done && (higher_req || !own_req)) begin
                    if (any_req) begin
                        grant_d     = pick_oh;
                        own_idx_d   = pick_idx;
                        lat_value_d = pick_value;
                        lat_dec_d   = pick_dec;
                        hold_cnt_d  = '0;
                        state_d     = ST_LOAD;
                    end else begin
                        grant_d      = '0;
                        disp_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end else if (own_req && ((own_value != lat_value_q) || (own_dec != lat_dec_q))) begin
                    // Owner updated its value: redisplay without restarting the hold.
                    lat_value_d = own_value;
                    lat_dec_d   = own_dec;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            own_idx_q     <= '0;
            lat_value_q   <= '0;
            lat_dec_q     <= 1'b0;
            conv_start_q  <= 1'b0;
            conv_binary_q <= '0;
            disp_value_q  <= '0;
            disp_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
            conv_error_q  <= 1'b0;
            hold_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            own_idx_q     <= own_idx_d;
            lat_value_q   <= lat_value_d;
            lat_dec_q     <= lat_dec_d;
            conv_start_q  <= conv_start_d;
            conv_binary_q <= conv_binary_d;
            disp_value_q  <= disp_value_d;
            disp_valid_q  <= disp_valid_d;
            overflow_q    <= overflow_d;
            conv_error_q  <= conv_error_d;
            hold_cnt_q    <= hold_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign conv_start  = conv_start_q;
    assign conv_binary = conv_binary_q;
    assign disp_value  = disp_value_q;
    assign disp_valid  = disp_valid_q;
    assign overflow    = overflow_q;
    assign conv_error  = conv_error_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: a vector table of single-shot displays plus
// hand-written hold, conversion, timeout and reset sequences.
module tb_display_arbiter;

    localparam int unsigned NUM_REQ = 3;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req = '0;
    logic [32*NUM_REQ-1:0] req_value = '0;
    logic [NUM_REQ-1:0]    req_decimal = '0;
    logic [NUM_REQ-1:0]    grant;
    logic                  conv_start;
    logic [31:0]           conv_binary;
    logic [31:0]           conv_bcd = '0;
    logic                  conv_done = 1'b0;
    logic [31:0]           disp_value;
    logic                  disp_valid;
    logic                  overflow;
    logic                  conv_error;

    int n_checks = 0;
    int n_fail   = 0;

    display_arbiter #(
        .NUM_REQ(NUM_REQ),
        .HOLD_CYCLES(16),
        .CONV_TIMEOUT(32)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req(req),
        .req_value(req_value),
        .req_decimal(req_decimal),
        .grant(grant),
        .conv_start(conv_start),
        .conv_binary(conv_binary),
        .conv_bcd(conv_bcd),
        .conv_done(conv_done),
        .disp_value(disp_value),
        .disp_valid(disp_valid),
        .overflow(overflow),
        .conv_error(conv_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  req;
        logic [95:0] vals;
        logic [2:0]  dec;
        logic [2:0]  exp_grant;
        logic [31:0] exp_disp;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        req         = '0;
        req_value   = '0;
        req_decimal = '0;
        conv_done   = 1'b0;
        conv_bcd    = '0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".grant"}, 32'(grant), 32'd0);
        check({name, ".conv_start"}, 32'(conv_start), 32'd0);
        check({name, ".conv_binary"}, conv_binary, 32'd0);
        check({name, ".disp_value"}, disp_value, 32'd0);
        check({name, ".disp_valid"}, 32'(disp_valid), 32'd0);
        check({name, ".overflow"}, 32'(overflow), 32'd0);
        check({name, ".conv_error"}, 32'(conv_error), 32'd0);
    endtask

    initial begin
        // req, {v2,v1,v0}, decimal, grant, display, overflow
        vecs[0] = '{3'b010, {32'h0, 32'h000000FF, 32'h0}, 3'b000, 3'b010, 32'h000000FF, 1'b0};
        vecs[1] = '{3'b011, {32'h0, 32'h11111111, 32'h1234ABCD}, 3'b000, 3'b001, 32'h1234ABCD, 1'b0};
        vecs[2] = '{3'b110, {32'h0, 32'd100000000, 32'h0}, 3'b010, 3'b010, 32'h05F5E100, 1'b1};
        vecs[3] = '{3'b100, {32'hFFFFFFFF, 32'h0, 32'h0}, 3'b100, 3'b100, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{3'b101, {32'd5, 32'h0, 32'hDEADBEEF}, 3'b100, 3'b001, 32'hDEADBEEF, 1'b0};

        do_reset();
        check_all_zero("reset");

        // Table: hex and out-of-range decimal show on the 2nd edge, no conversion.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            req         = vecs[v].req;
            req_value   = vecs[v].vals;
            req_decimal = vecs[v].dec;
            tick();
            check($sformatf("vec%0d.grant1", v), 32'(grant), 32'(vecs[v].exp_grant));
            check($sformatf("vec%0d.valid1", v), 32'(disp_valid), 32'd0);
            check($sformatf("vec%0d.start1", v), 32'(conv_start), 32'd0);
            tick();
            check($sformatf("vec%0d.disp", v), disp_value, vecs[v].exp_disp);
            check($sformatf("vec%0d.valid2", v), 32'(disp_valid), 32'd1);
            check($sformatf("vec%0d.ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check($sformatf("vec%0d.start2", v), 32'(conv_start), 32'd0);
            check($sformatf("vec%0d.grant2", v), 32'(grant), 32'(vecs[v].exp_grant));
        end

        // Decimal conversion with converter answering ten cycles after start.
        do_reset();
        req = 3'b100;
        req_value = {32'd255, 64'h0};
        req_decimal = 3'b100;
        tick();
        check("conv.grant", 32'(grant), 32'h4);
        check("conv.start0", 32'(conv_start), 32'd0);
        tick();
        check("conv.start1", 32'(conv_start), 32'd1);
        check("conv.binary", conv_binary, 32'd255);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("conv.wait%0d.start", i), 32'(conv_start), 32'd0);
            check($sformatf("conv.wait%0d.binary", i), conv_binary, 32'd255);
            check($sformatf("conv.wait%0d.valid", i), 32'(disp_valid), 32'd0);
        end
        conv_done = 1'b1;
        conv_bcd  = 32'h00000255;
        tick();
        conv_done = 1'b0;
        conv_bcd  = '0;
        check("conv.disp", disp_value, 32'h00000255);
        check("conv.valid", 32'(disp_valid), 32'd1);
        check("conv.err", 32'(conv_error), 32'd0);

        // Hold: higher-priority request and owner drop wait for the hold to expire.
        do_reset();
        req = 3'b010;
        req_value = {32'h0, 32'h000000FF, 32'h00C0FFEE};
        req_decimal = 3'b000;
        tick();
        check("hold.grant0", 32'(grant), 32'h2);
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 3) req = 3'b011;
            if (e == 5) req = 3'b001;
            check($sformatf("hold.e%0d.grant", e), 32'(grant), 32'h2);
            check($sformatf("hold.e%0d.disp", e), disp_value, 32'h000000FF);
            check($sformatf("hold.e%0d.valid", e), 32'(disp_valid), 32'd1);
        end
        tick();
        check("hold.regrant", 32'(grant), 32'h1);
        tick();
        check("hold.newdisp", disp_value, 32'h00C0FFEE);
        check("hold.newvalid", 32'(disp_valid), 32'd1);

        // Owner refresh: changed value is redisplayed under the same grant.
        do_reset();
        req = 3'b010;
        req_value = {32'h0, 32'h00000011, 32'h0};
        tick();
        tick();
        check("refr.disp0", disp_value, 32'h00000011);
        req_value = {32'h0, 32'h00000022, 32'h0};
        tick();
        check("refr.grant", 32'(grant), 32'h2);
        tick();
        check("refr.disp1", disp_value, 32'h00000022);
        check("refr.valid", 32'(disp_valid), 32'd1);

        // Silent converter: timeout after 32 CONVERT cycles, late conv_done ignored.
        do_reset();
        req = 3'b001;
        req_value = {64'h0, 32'd42};
        req_decimal = 3'b001;
        tick();
        tick();
        check("tmo.start", 32'(conv_start), 32'd1);
        for (int e = 1; e <= 31; e++) begin
            tick();
            check($sformatf("tmo.e%0d.err", e), 32'(conv_error), 32'd0);
            check($sformatf("tmo.e%0d.valid", e), 32'(disp_valid), 32'd0);
        end
        tick();
        check("tmo.err", 32'(conv_error), 32'd1);
        check("tmo.disp", disp_value, 32'h0000002A);
        check("tmo.valid", 32'(disp_valid), 32'd1);
        conv_done = 1'b1;
        conv_bcd  = 32'h00000099;
        tick();
        conv_done = 1'b0;
        tick();
        check("tmo.late.disp", disp_value, 32'h0000002A);
        check("tmo.late.err", 32'(conv_error), 32'd1);
        check("tmo.late.start", 32'(conv_start), 32'd0);

        // Asynchronous reset in the middle of a conversion.
        do_reset();
        req = 3'b001;
        req_value = {64'h0, 32'd7};
        req_decimal = 3'b001;
        tick();
        tick();
        tick();
        tick();
        check("rst.pre.grant", 32'(grant), 32'h1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        req = '0;
        #2;
        reset_n = 1'b1;
        conv_done = 1'b1;
        conv_bcd  = 32'h00000007;
        tick();
        conv_done = 1'b0;
        check_all_zero("rst.done");
        tick();
        tick();
        check("rst.idle.grant", 32'(grant), 32'd0);
        req = 3'b010;
        req_value = {32'h0, 32'h0000ABCD, 32'h0};
        req_decimal = 3'b000;
        tick();
        check("rst.new.grant", 32'(grant), 32'h2);
        tick();
        check("rst.new.disp", disp_value, 32'h0000ABCD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
